// File: rtl/arb_out_fifo.sv
// arb_out_fifo: elastic output buffer behind the 2-input round-robin arbiter.
// The arbiter has no backpressure, so words are absorbed into a DEPTH-entry
// FIFO and re-issued on a valid/ready handshake. A word that arrives while the
// FIFO is full and not draining is dropped. Each drop is reported by a
// one-cycle pulse and counted in a saturating counter.
module arb_out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [15:0]              o_drop_cnt
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned DROP_W    = 16;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Storage and bookkeeping state
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              drop_q;
    logic [DROP_W-1:0] drop_cnt_q;

    // Per-cycle handshake decisions
    logic pop_c;
    logic push_ok_c;
    logic drop_c;
    logic is_full_c;
    logic is_empty_c;

    // Occupancy flags are derived from the registered count only
    always_comb begin
        is_full_c  = (cnt == CNT_FULL);
        is_empty_c = (cnt == '0);
    end

    // Pop when the head is valid and the consumer is ready. A push is accepted
    // if there is room, or if the FIFO is full and a slot frees this cycle.
    always_comb begin
        pop_c     = 1'b0;
        push_ok_c = 1'b0;
        drop_c    = 1'b0;
        if (!is_empty_c && i_ready) begin
            pop_c = 1'b1;
        end
        if (i_valid) begin
            if (!is_full_c || pop_c) begin
                push_ok_c = 1'b1;
            end else begin
                drop_c = 1'b1;
            end
        end
    end

    // Data array: no reset; writes are suppressed while reset is asserted
    always_ff @(posedge i_clk) begin
        if (i_reset_n && push_ok_c) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy counter. Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Drop pulse for the previous cycle and saturating drop counter
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q <= drop_c;
            if (drop_c && (drop_cnt_q != DROP_MAX)) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
        end
    end

    // Output mapping: the head word is read straight from registered storage
    always_comb begin
        o_valid    = !is_empty_c;
        o_data     = mem[rd_ptr];
        o_count    = cnt;
        o_full     = is_full_c;
        o_empty    = is_empty_c;
        o_drop     = drop_q;
        o_drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_arb_out_fifo.sv
// Directed testbench for arb_out_fifo (WIDTH=16, DEPTH=8).
module tb_arb_out_fifo;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_valid;
    logic [15:0] o_data;
    logic        i_ready;
    logic [3:0]  o_count;
    logic        o_full;
    logic        o_empty;
    logic        o_drop;
    logic [15:0] o_drop_cnt;

    int n_checks;
    int n_fail;
    int exp_drop_cnt;

    arb_out_fifo #(.WIDTH(16), .DEPTH(8)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One clock edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_1_to_8();
        i_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            i_valid = 1'b1;
            i_data  = 16'(k);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic drain_bounded();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 20 && !o_empty; k++) tick();
        n_checks++;
        if (o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_timeout: o_empty=%b required 1", o_empty);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = 16'h0;
        i_ready   = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", o_valid); end
        n_checks++;
        if (o_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", o_count); end
        n_checks++;
        if (o_empty !== 1'b1 || o_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: empty=%b full=%b required 1 0", o_empty, o_full);
        end
        n_checks++;
        if (o_drop !== 1'b0 || o_drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_drop: drop=%b cnt=%0d required 0 0", o_drop, o_drop_cnt);
        end
        exp_drop_cnt = 0;
    endtask

    task automatic test_single();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'hA5A5;
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 16'hA5A5) begin
            n_fail++; $display("FAIL single_head: valid=%b data=%h required 1 a5a5", o_valid, o_data);
        end
        n_checks++;
        if (o_count !== 4'd1) begin n_fail++; $display("FAIL single_count1: got %0d required 1", o_count); end
        tick();
        n_checks++;
        if (o_count !== 4'd0 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_popped: count=%0d valid=%b required 0 0", o_count, o_valid);
        end
    endtask

    task automatic test_fill_drain();
        fill_1_to_8();
        n_checks++;
        if (o_full !== 1'b1 || o_count !== 4'd8) begin
            n_fail++; $display("FAIL fill_full: full=%b count=%0d required 1 8", o_full, o_count);
        end
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 16'(k)) begin
                n_fail++; $display("FAIL drain_order: valid=%b data=%h required 1 %h", o_valid, o_data, 16'(k));
            end
            tick();
        end
        n_checks++;
        if (o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b required 1", o_empty); end
        i_ready = 1'b0;
    endtask

    task automatic test_overflow();
        fill_1_to_8();
        i_valid = 1'b1;
        i_data  = 16'hDEAD;
        tick();
        n_checks++;
        if (o_drop !== 1'b1 || o_drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL ovf_first: drop=%b cnt=%0d required 1 1", o_drop, o_drop_cnt);
        end
        i_data = 16'hBEEF;
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_drop !== 1'b1 || o_drop_cnt !== 16'd2) begin
            n_fail++; $display("FAIL ovf_second: drop=%b cnt=%0d required 1 2", o_drop, o_drop_cnt);
        end
        tick();
        n_checks++;
        if (o_drop !== 1'b0 || o_drop_cnt !== 16'd2 || o_count !== 4'd8) begin
            n_fail++; $display("FAIL ovf_after: drop=%b cnt=%0d count=%0d required 0 2 8", o_drop, o_drop_cnt, o_count);
        end
        exp_drop_cnt = 2;
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 16'(k)) begin
                n_fail++; $display("FAIL ovf_drain: valid=%b data=%h required 1 %h", o_valid, o_data, 16'(k));
            end
            tick();
        end
        n_checks++;
        if (o_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b required 1", o_empty); end
        i_ready = 1'b0;
    endtask

    task automatic test_passthrough();
        fill_1_to_8();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h1234;
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        n_checks++;
        if (o_count !== 4'd8 || o_drop !== 1'b0 || o_drop_cnt !== 16'd2) begin
            n_fail++; $display("FAIL pass_count: count=%0d drop=%b cnt=%0d required 8 0 2", o_count, o_drop, o_drop_cnt);
        end
        i_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            logic [15:0] exp_w;
            exp_w = (k == 9) ? 16'h1234 : 16'(k);
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== exp_w) begin
                n_fail++; $display("FAIL pass_order: valid=%b data=%h required 1 %h", o_valid, o_data, exp_w);
            end
            tick();
        end
        n_checks++;
        if (o_empty !== 1'b1) begin n_fail++; $display("FAIL pass_empty: got %b required 1", o_empty); end
        i_ready = 1'b0;
    endtask

    task automatic test_random_backpressure();
        logic [15:0] q[$];
        int          pushes;
        int          cycles;
        logic        prev_hold;
        logic [15:0] prev_head;
        logic        exp_drop;
        logic        v;
        logic        r;
        logic        pop;
        logic        acc;
        pushes    = 0;
        cycles    = 0;
        prev_hold = 1'b0;
        prev_head = 16'h0;
        while (pushes < 1000 && cycles < 20000) begin
            v = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 1) == 1;
            i_valid = v;
            i_ready = r;
            i_data  = 16'($urandom);
            #0;
            n_checks++;
            if (o_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid: got %b required %b", o_valid, q.size() != 0);
            end
            n_checks++;
            if (o_count !== 4'(q.size())) begin
                n_fail++; $display("FAIL rnd_count: got %0d required %0d", o_count, q.size());
            end
            if (q.size() != 0) begin
                n_checks++;
                if (o_data !== q[0]) begin
                    n_fail++; $display("FAIL rnd_data: got %h required %h", o_data, q[0]);
                end
            end
            if (prev_hold) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== prev_head) begin
                    n_fail++; $display("FAIL rnd_stable: valid=%b data=%h required 1 %h", o_valid, o_data, prev_head);
                end
            end
            pop = (q.size() != 0) && r;
            acc = v && ((q.size() < 8) || pop);
            exp_drop = v && !acc;
            prev_hold = (q.size() != 0) && !r;
            if (q.size() != 0) prev_head = q[0];
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(i_data);
            if (exp_drop && exp_drop_cnt < 65535) exp_drop_cnt++;
            if (v) pushes++;
            cycles++;
            tick();
            n_checks++;
            if (o_drop !== exp_drop) begin
                n_fail++; $display("FAIL rnd_drop: got %b required %b", o_drop, exp_drop);
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        n_checks++;
        if (pushes < 1000) begin n_fail++; $display("FAIL rnd_budget: pushes=%0d required 1000", pushes); end
        n_checks++;
        if (o_drop_cnt !== 16'(exp_drop_cnt)) begin
            n_fail++; $display("FAIL rnd_drop_cnt: got %0d required %0d", o_drop_cnt, exp_drop_cnt);
        end
        i_ready = 1'b1;
        while (q.size() != 0) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== q[0]) begin
                n_fail++; $display("FAIL rnd_tail: valid=%b data=%h required 1 %h", o_valid, o_data, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        n_checks++;
        if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rnd_empty: got %b required 1", o_empty); end
        i_ready = 1'b0;
    endtask

    task automatic test_midstream_reset();
        drain_bounded();
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = 16'h0011 + 16'(k);
            tick();
        end
        n_checks++;
        if (o_count !== 4'd5) begin n_fail++; $display("FAIL mrst_pre: count=%0d required 5", o_count); end
        i_reset_n = 1'b0;
        i_valid   = 1'b1;
        i_ready   = 1'b1;
        i_data    = 16'hFFFF;
        tick();
        i_reset_n = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_count !== 4'd0 || o_drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mrst_state: valid=%b count=%0d dcnt=%0d required 0 0 0", o_valid, o_count, o_drop_cnt);
        end
        i_valid = 1'b1;
        i_data  = 16'h0077;
        tick();
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1 || o_data !== 16'h0077 || o_count !== 4'd1) begin
            n_fail++; $display("FAIL mrst_first: valid=%b data=%h count=%0d required 1 0077 1", o_valid, o_data, o_count);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        exp_drop_cnt = 0;
        i_reset_n    = 1'b0;
        i_valid      = 1'b0;
        i_data       = 16'h0;
        i_ready      = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_passthrough();
        test_random_backpressure();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_out_fifo.md
# arb_out_fifo

Elastic output buffer placed directly downstream of the 2-input round-robin arbiter. It absorbs the arbiter's unflow-controlled valid/data stream, which has no backpressure, into a DEPTH-entry FIFO. It re-issues the words to the consumer over a valid/ready handshake. Words arriving while the FIFO is full and not draining are dropped and counted, so overload is visible rather than silent.

## Interface
- WIDTH, 16, data word width; matches arbiter output width
- DEPTH, 8, number of entries; power of two, ≥ 2
- i_clk  in  1  clock; all state updates on rising edge
- i_reset_n  in  1  synchronous, active-low reset, sampled on rising edge of i_clk
- i_valid  in  1  arbiter output valid; no ready is returned upstream
- i_data  in  WIDTH  arbiter output data, meaningful only when i_valid=1
- o_valid  out  1  FIFO head valid to consumer
- o_data  out  WIDTH  FIFO head word
- i_ready  in  1  consumer accepts head this cycle when o_valid=1
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0
- o_drop  out  1  one-cycle pulse, registered: a word was dropped in the previous cycle
- o_drop_cnt  out  16  saturating count of dropped words

## Operation
- Storage: DEPTH×WIDTH register array; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH; occupancy counter cnt.
- Push: a push is attempted when i_valid=1.
- Pop: a pop occurs when o_valid=1 and i_ready=1.
- Push acceptance: an attempted push is accepted when cnt<DEPTH, or when cnt==DEPTH and a pop occurs in the same cycle (full pass-through).
  - Accepted push: mem[wr_ptr]<=i_data and wr_ptr increments.
- Pop: rd_ptr increments.
- Count update: cnt <= cnt + push_accepted − pop.
- Drop: an attempted push that is not accepted (cnt==DEPTH and no pop) is dropped.
  - Stored data is unchanged.
  - o_drop=1 on the next cycle.
  - o_drop_cnt increments, saturating at 16'hFFFF.
- o_valid = !o_empty; o_data = mem[rd_ptr], combinational read of registered storage.
- No bypass: a word pushed into an empty FIFO is not visible until the following cycle.
- o_data while o_valid=0 is don't-care; the bench must not check it.
- i_ready while o_valid=0 is ignored and produces no state change.
- Flow control: the consumer may hold i_ready low indefinitely. Head data and o_valid must stay stable while o_valid=1 and i_ready=0.
- Reset (i_reset_n=0 at a rising edge) sets wr_ptr=0, rd_ptr=0, cnt=0, o_drop=0, o_drop_cnt=0. Array contents are not cleared.
  - Reset asserted mid-stream discards all buffered words; no partial pop or push completes in the reset cycle.
  - Inputs are ignored in the reset cycle.

## Timing
- Reset values: o_valid=0, o_count=0, o_empty=1, o_full=0, o_drop=0, o_drop_cnt=0; o_data undefined.
- Latency from push at edge N to o_valid=1: 1 cycle. The word is visible after edge N.
- Throughput: 1 push and 1 pop per cycle sustained. An occupancy of k stays constant under a continuous matched push/pop.
- o_count, o_full and o_empty are registered-state derived. They reflect the state after the last edge, not the current-cycle push/pop.
- Boundary cases:
  - Empty + push + i_ready=1: push accepted, no pop (o_valid=0); cnt goes 0→1.
  - Full + push + pop: both occur and cnt stays at DEPTH; the new word lands at the freed slot, wr_ptr==rd_ptr_old.
  - Full + push, no pop: drop.
  - Full, no push, pop: cnt goes DEPTH→DEPTH−1.
  - Pointer wrap from DEPTH−1 to 0 must preserve order.
- The saturating drop counter holds at FFFF and never wraps to 0 except on reset.

## Test plan
- Reset then single word: hold reset 2 cycles. Push 16'hA5A5 with i_ready=1.
  - Required: o_valid=1 exactly one cycle later with o_data=A5A5, popped that cycle.
  - Required: o_count returns to 0.
- Fill and drain: i_ready=0, push 16'h0001..16'h0008 on consecutive cycles.
  - Required: o_full=1 and o_count=8.
  - Then i_ready=1 with no pushes. Required: output sequence 0001..0008 in order, then o_empty=1.
- Overflow: with full FIFO holding 0001..0008 and i_ready=0, push 16'hDEAD and 16'hBEEF.
  - Required: o_drop pulses 2 cycles and o_drop_cnt=2.
  - Required: drain yields exactly 0001..0008.
- Full pass-through: full FIFO, i_ready=1 and push 16'h1234 in the same cycle.
  - Required: o_count stays 8, no drop.
  - Required: 1234 emerges 8th after the current head.
- Wrap and backpressure: random i_ready at ~50% over 1000 pushes at ~40% rate, DEPTH=8.
  - Required: output equals a scoreboard model including drops.
  - Required: head is stable while i_ready=0.
  - Required: no loss across pointer wrap.
- Mid-stream reset: 5 words buffered, assert i_reset_n=0 for 1 cycle with i_valid=1.
  - Required: o_valid=0, o_count=0, o_drop_cnt=0 after the edge.
  - Required: the next push is the first word out.
